// File: rtl/reg_watch_pkg.sv
// Shared types for the register watch/trace block: event kinds, FSM states, trace header.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package reg_watch_pkg;

    // Event kind carried in the top two bits of every trace entry.
    typedef enum logic [1:0] {
        KIND_W  = 2'd0,
        KIND_R1 = 2'd1,
        KIND_R2 = 2'd2
    } kind_t;

    // Capture state: RUN records events, FROZEN holds the trace after a drop.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    localparam int SLOT_W = 3;

    // Fixed-width leading part of a trace entry; addr and data follow it.
    typedef struct packed {
        kind_t             kind;
        logic [SLOT_W-1:0] slot;
    } trace_hdr_t;

    localparam int HDR_W = $bits(trace_hdr_t);

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through FIFO holding trace entries.
// Latency: a push is visible at head_dat the cycle after it is written into an empty FIFO.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Head reads as zero when empty so the output is clean out of reset.
    assign head_dat = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage array is not reset; entries are only observable once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/reg_watch_trace.sv
// Watches register-file read/write ports against configurable address slots and traces hits.
// Latency: an event captured in cycle t appears on tr_valid/tr_data in cycle t+1 if the FIFO was empty.
// Backpressure: tr_ready low stalls the FIFO; events arriving when it is full are dropped and counted.
module reg_watch_trace
    import reg_watch_pkg::*;
#(
    parameter int N      = 8,
    parameter int AW     = 5,
    parameter int NWATCH = 4,
    parameter int DEPTH  = 8,
    parameter int CW     = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [AW-1:0]                           rd1_addr,
    input  logic [AW-1:0]                           rd2_addr,
    input  logic [N-1:0]                            rd1_data,
    input  logic [N-1:0]                            rd2_data,
    input  logic                                    wr_en,
    input  logic [AW-1:0]                           wr_addr,
    input  logic [N-1:0]                            wr_data,
    input  logic                                    cfg_we,
    input  logic [((NWATCH>1)?$clog2(NWATCH):1)-1:0] cfg_idx,
    input  logic [AW-1:0]                           cfg_addr,
    input  logic [2:0]                              cfg_mask,
    input  logic                                    cfg_stop,
    input  logic                                    clear,
    output logic                                    tr_valid,
    input  logic                                    tr_ready,
    output logic [2+3+AW+N-1:0]                     tr_data,
    output logic                                    frozen,
    output logic [CW-1:0]                           drop_count
);
    localparam int TW = HDR_W + AW + N;

    logic [AW-1:0]     slot_addr [NWATCH];
    logic [2:0]        slot_mask [NWATCH];
    logic [2:0]        hit;
    logic [SLOT_W-1:0] w_slot, r1_slot, r2_slot;
    trace_hdr_t        ev_hdr;
    logic [AW-1:0]     ev_addr;
    logic [N-1:0]      ev_dat;
    logic [1:0]        n_lost;
    logic [1:0]        drops;
    logic              push, pop, cnt_clear;
    logic              fifo_full, fifo_empty;
    logic [CW:0]       drop_sum;
    state_t            state_q, state_d;

    // Slot configuration; a write takes effect from the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NWATCH; i++) begin
                slot_addr[i] <= '0;
                slot_mask[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_idx) < NWATCH)) begin
            slot_addr[cfg_idx] <= cfg_addr;
            slot_mask[cfg_idx] <= cfg_mask;
        end
    end

    // Per-port match; scanning high to low leaves the lowest matching slot.
    always_comb begin
        hit     = '0;
        w_slot  = '0;
        r1_slot = '0;
        r2_slot = '0;
        for (int i = NWATCH - 1; i >= 0; i--) begin
            if (wr_en && slot_mask[i][0] && slot_addr[i] == wr_addr) begin
                hit[0] = 1'b1;
                w_slot = SLOT_W'(i);
            end
            if (slot_mask[i][1] && slot_addr[i] == rd1_addr) begin
                hit[1]  = 1'b1;
                r1_slot = SLOT_W'(i);
            end
            if (slot_mask[i][2] && slot_addr[i] == rd2_addr) begin
                hit[2]  = 1'b1;
                r2_slot = SLOT_W'(i);
            end
        end
    end

    // Pick the single event to trace (W > R1 > R2); every other hit is lost.
    always_comb begin
        ev_hdr.kind = KIND_W;
        ev_hdr.slot = w_slot;
        ev_addr     = wr_addr;
        ev_dat      = wr_data;
        if (!hit[0]) begin
            if (hit[1]) begin
                ev_hdr.kind = KIND_R1;
                ev_hdr.slot = r1_slot;
                ev_addr     = rd1_addr;
                ev_dat      = rd1_data;
            end else begin
                ev_hdr.kind = KIND_R2;
                ev_hdr.slot = r2_slot;
                ev_addr     = rd2_addr;
                ev_dat      = rd2_data;
            end
        end
        n_lost = 2'(hit[0]) + 2'(hit[1]) + 2'(hit[2]) - 2'(|hit);
    end

    assign pop      = tr_valid && tr_ready;
    assign tr_valid = !fifo_empty;
    assign frozen   = (state_q == ST_FROZEN);

    trace_fifo #(
        .WIDTH (TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat ({ev_hdr, ev_addr, ev_dat}),
        .pop      (pop),
        .head_dat (tr_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Capture state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Capture FSM: decides push, drop amount and counter clear for this cycle.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        drops     = '0;
        cnt_clear = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                push  = |hit;
                drops = n_lost + 2'(push && fifo_full && !pop);
                if (clear) begin
                    cnt_clear = 1'b1;
                end else if (cfg_stop && drops != '0) begin
                    state_d = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (clear) begin
                    state_d   = ST_RUN;
                    cnt_clear = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign drop_sum = {1'b0, drop_count} + (CW+1)'(drops);

    // Saturating drop counter; clear wins over any drops in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) drop_count <= '0;
        else if (drop_sum[CW])  drop_count <= '1;
        else                    drop_count <= drop_sum[CW-1:0];
    end

endmodule

// File: tb/tb_reg_watch_trace.sv
// Randomized plus directed bench for reg_watch_trace with a queue-based reference model.
// Latency: model entries become visible one cycle after the capturing edge.
// Backpressure: tr_ready is driven randomly; a negedge monitor pops the expected queue on handshakes.
module tb_reg_watch_trace;
    localparam int N      = 8;
    localparam int AW     = 5;
    localparam int NWATCH = 4;
    localparam int DEPTH  = 8;
    localparam int CW     = 4;
    localparam int TW     = 5 + AW + N;
    localparam int MAXCNT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rd1_addr, rd2_addr, wr_addr, cfg_addr;
    logic [N-1:0]  rd1_data, rd2_data, wr_data;
    logic          wr_en, cfg_we, cfg_stop, clear, tr_ready;
    logic [1:0]    cfg_idx;
    logic [2:0]    cfg_mask;
    logic          tr_valid, frozen;
    logic [TW-1:0] tr_data;
    logic [CW-1:0] drop_count;

    reg_watch_trace #(
        .N(N), .AW(AW), .NWATCH(NWATCH), .DEPTH(DEPTH), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_data(rd1_data), .rd2_data(rd2_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask),
        .cfg_stop(cfg_stop), .clear(clear),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_data(tr_data),
        .frozen(frozen), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef logic [TW-1:0] ent_t;
    ent_t exp_q[$];
    int   m_addr [NWATCH];
    int   m_mask [NWATCH];
    int   m_drops  = 0;
    bit   m_frozen = 0;
    bit   mon_en   = 0;
    int   n_vec    = 0;
    int   n_bad    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lowest-indexed slot watching this port at this address, or -1.
    function automatic int find(input int port, input logic en, input logic [AW-1:0] a);
        for (int i = 0; i < NWATCH; i++)
            if (en && m_mask[i][port] && m_addr[i] == int'(a)) return i;
        return -1;
    endfunction

    // Apply current inputs for one clock, advancing the reference model alongside.
    task automatic cycle();
        int   occ, sw, s1, s2, hits, d, nd;
        bit   pop, p_push, p_reset, nf;
        ent_t e;
        occ     = exp_q.size();
        pop     = (occ > 0) && tr_ready;
        p_push  = 0;
        p_reset = reset;
        nd      = m_drops;
        nf      = m_frozen;
        e       = '0;
        if (reset) begin
            for (int i = 0; i < NWATCH; i++) begin
                m_addr[i] = 0;
                m_mask[i] = 0;
            end
            nd = 0;
            nf = 0;
        end else begin
            sw   = find(0, wr_en, wr_addr);
            s1   = find(1, 1'b1, rd1_addr);
            s2   = find(2, 1'b1, rd2_addr);
            hits = int'(sw >= 0) + int'(s1 >= 0) + int'(s2 >= 0);
            if (sw >= 0)      e = {2'd0, 3'(sw), wr_addr, wr_data};
            else if (s1 >= 0) e = {2'd1, 3'(s1), rd1_addr, rd1_data};
            else if (s2 >= 0) e = {2'd2, 3'(s2), rd2_addr, rd2_data};
            if (m_frozen) begin
                if (clear) begin
                    nf = 0;
                    nd = 0;
                end
            end else begin
                d = (hits > 0) ? hits - 1 : 0;
                if (hits > 0) begin
                    if (occ == DEPTH && !pop) d++;
                    else p_push = 1;
                end
                if (clear) begin
                    nd = 0;
                end else begin
                    nd = (m_drops + d > MAXCNT) ? MAXCNT : m_drops + d;
                    if (cfg_stop && d > 0) nf = 1;
                end
            end
            if (cfg_we && int'(cfg_idx) < NWATCH) begin
                m_addr[cfg_idx] = int'(cfg_addr);
                m_mask[cfg_idx] = int'(cfg_mask);
            end
        end
        @(posedge clk);
        #1;
        if (p_reset) exp_q.delete();
        if (p_push)  exp_q.push_back(e);
        m_drops  = nd;
        m_frozen = nf;
    endtask

    task automatic idle();
        reset = 0; wr_en = 0; cfg_we = 0; clear = 0;
        wr_addr = 5'd31; rd1_addr = 5'd31; rd2_addr = 5'd31;
        wr_data = '0; rd1_data = '0; rd2_data = '0;
        cfg_idx = '0; cfg_addr = '0; cfg_mask = '0;
    endtask

    task automatic cfg(input int idx, input int addr, input int mask);
        idle();
        cfg_we = 1; cfg_idx = 2'(idx); cfg_addr = AW'(addr); cfg_mask = 3'(mask);
        cycle();
        idle();
    endtask

    // Monitor: compares the DUT outputs with the model every cycle, popping on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("tr_valid", 64'(tr_valid), 64'(exp_q.size() != 0));
            if (tr_valid && exp_q.size() > 0) begin
                chk("tr_data", 64'(tr_data), 64'(exp_q[0]));
                if (tr_ready) void'(exp_q.pop_front());
            end
            chk("drop_count", 64'(drop_count), 64'(m_drops));
            chk("frozen", 64'(frozen), 64'(m_frozen));
        end
    end

    initial begin
        idle();
        tr_ready = 0; cfg_stop = 0; reset = 1;
        cycle();
        cycle();
        reset = 0;
        mon_en = 1;
        chk("rst_valid", 64'(tr_valid), 64'(0));
        chk("rst_data", 64'(tr_data), 64'(0));
        chk("rst_drops", 64'(drop_count), 64'(0));
        chk("rst_frozen", 64'(frozen), 64'(0));

        // Single write hit, first-word-fall-through.
        cfg(0, 5, 1);
        wr_en = 1; wr_addr = 5'd5; wr_data = 8'hA5;
        cycle(); idle();
        chk("w_valid", 64'(tr_valid), 64'(1));
        chk("w_data", 64'(tr_data), 64'({2'd0, 3'd0, 5'd5, 8'hA5}));
        tr_ready = 1; cycle(); tr_ready = 0;

        // Three simultaneous hits: W wins, two drops.
        cfg(0, 6, 7);
        wr_en = 1; wr_addr = 5'd6; rd1_addr = 5'd6; rd2_addr = 5'd6; wr_data = 8'h3C;
        cycle(); idle();
        chk("prio_drops", 64'(drop_count), 64'(2));
        chk("prio_data", 64'(tr_data), 64'({2'd0, 3'd0, 5'd6, 8'h3C}));
        tr_ready = 1; clear = 1; cycle(); idle(); tr_ready = 0;
        chk("clr_drops", 64'(drop_count), 64'(0));

        // Overflow while stalled, then drain in order.
        cfg(0, 6, 1);
        for (int i = 0; i < 10; i++) begin
            wr_en = 1; wr_addr = 5'd6; wr_data = 8'(16 + i);
            cycle();
        end
        idle();
        chk("ovf_drops", 64'(drop_count), 64'(2));
        chk("ovf_head", 64'(tr_data), 64'({2'd0, 3'd0, 5'd6, 8'd16}));
        tr_ready = 1; repeat (9) cycle();
        chk("ovf_drained", 64'(tr_valid), 64'(0));
        clear = 1; cycle(); idle(); tr_ready = 0;

        // Freeze on first drop.
        cfg_stop = 1;
        for (int i = 0; i < 9; i++) begin
            wr_en = 1; wr_addr = 5'd6; wr_data = 8'(64 + i);
            cycle();
        end
        idle();
        chk("frz_on", 64'(frozen), 64'(1));
        chk("frz_drops", 64'(drop_count), 64'(1));
        for (int i = 0; i < 2; i++) begin
            wr_en = 1; wr_addr = 5'd6; wr_data = 8'hEE;
            cycle();
        end
        idle();
        chk("frz_hold", 64'(drop_count), 64'(1));
        clear = 1; cycle(); idle();
        chk("frz_off", 64'(frozen), 64'(0));
        chk("frz_clr", 64'(drop_count), 64'(0));
        cfg_stop = 0; tr_ready = 1; repeat (9) cycle();
        chk("frz_drained", 64'(tr_valid), 64'(0));

        // Lowest slot wins; reset mid-stream discards everything.
        cfg(0, 0, 0); cfg(1, 7, 2); cfg(3, 7, 2);
        tr_ready = 0;
        rd1_addr = 5'd7; rd1_data = 8'h77;
        cycle(); idle();
        chk("low_slot", 64'(tr_data[TW-3 -: 3]), 64'(1));
        chk("low_data", 64'(tr_data), 64'({2'd1, 3'd1, 5'd7, 8'h77}));
        rd1_addr = 5'd7; cycle(); cycle();
        reset = 1; cycle(); idle();
        chk("mid_rst_valid", 64'(tr_valid), 64'(0));
        chk("mid_rst_drops", 64'(drop_count), 64'(0));

        // Randomized traffic against the model.
        for (int blk = 0; blk < 12; blk++) begin
            cfg_stop = 1'($urandom_range(0, 1));
            for (int c = 0; c < 200; c++) begin
                reset    = ($urandom_range(0, 199) == 0);
                clear    = ($urandom_range(0, 29) == 0);
                wr_en    = 1'($urandom_range(0, 1));
                wr_addr  = AW'($urandom_range(0, 3));
                rd1_addr = AW'($urandom_range(0, 3));
                rd2_addr = AW'($urandom_range(0, 3));
                wr_data  = N'($urandom);
                rd1_data = N'($urandom);
                rd2_data = N'($urandom);
                cfg_we   = ($urandom_range(0, 7) == 0);
                cfg_idx  = 2'($urandom_range(0, NWATCH - 1));
                cfg_addr = AW'($urandom_range(0, 3));
                cfg_mask = 3'($urandom_range(0, 7));
                tr_ready = ($urandom_range(0, 9) < (blk % 5) * 2 + 1);
                cycle();
            end
        end
        idle();
        tr_ready = 1;
        repeat (DEPTH + 2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
